// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: edge-captured, maskable, fixed-priority interrupt controller
// sitting between the board interrupt sources and the MCU INTR input.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | INTR low; arbitrate among pending and enabled sources
// ST_ASSERT    | INTR high for INTR_CYCLES cycles; ACTIVE_ID frozen
// ST_WAIT_ACK  | INTR low; wait for a CLAIM write naming ACTIVE_ID
// ST_GAP       | INTR low for GAP_CYCLES cycles after the acknowledge
module otter_intr_ctrl #(
    parameter int          NUM_SRC     = 4,
    parameter logic [31:0] BASE_AD     = 32'h11000200,
    parameter int          INTR_CYCLES = 4,
    parameter int          GAP_CYCLES  = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        RD_DATA,
    output logic               RD_HIT,
    output logic               INTR
);

    localparam int CNT_MAX = (INTR_CYCLES > GAP_CYCLES) ? INTR_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [31:0] AD_PEND  = BASE_AD;
    localparam logic [31:0] AD_MASK  = BASE_AD + 32'h4;
    localparam logic [31:0] AD_CLAIM = BASE_AD + 32'h8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         active_id, active_id_nxt, win_id;
    logic               intr_q, intr_nxt;

    logic [NUM_SRC-1:0] pend, mask, prev;
    logic [NUM_SRC-1:0] src_rise, elig, w1c_clr, claim_clr;
    logic               hit_pend, hit_mask, hit_claim;
    logic               wr_pend, wr_mask, wr_claim;
    logic [3:0]         claim_id;
    logic               claim_match, claim_vis;
    logic               unused_wdata;

    assign hit_pend    = (IOBUS_ADDR == AD_PEND);
    assign hit_mask    = (IOBUS_ADDR == AD_MASK);
    assign hit_claim   = (IOBUS_ADDR == AD_CLAIM);
    assign wr_pend     = IOBUS_WR && hit_pend;
    assign wr_mask     = IOBUS_WR && hit_mask;
    assign wr_claim    = IOBUS_WR && hit_claim;
    assign claim_id    = IOBUS_OUT[3:0];
    assign claim_match = wr_claim && (claim_id == active_id);
    assign src_rise    = IRQ_SRC & ~prev;
    assign elig        = pend & mask;
    assign w1c_clr     = wr_pend ? IOBUS_OUT[NUM_SRC-1:0] : '0;
    assign unused_wdata = ^IOBUS_OUT;

    // CLAIM write decodes to a one-hot clear; IDs with no source simply match nothing
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = wr_claim && (claim_id == 4'(i));
        end
    end

    // Fixed priority: the lowest eligible index wins
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id = 4'(i);
            end
        end
    end

    // Edge capture, pending bits (a new edge beats a same-cycle clear) and mask register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            prev <= '0;
            pend <= '0;
            mask <= '0;
        end else begin
            prev <= IRQ_SRC;
            pend <= (pend & ~(w1c_clr | claim_clr)) | src_rise;
            if (wr_mask) begin
                mask <= IOBUS_OUT[NUM_SRC-1:0];
            end
        end
    end

    // FSM state register together with its timer, latched winner and INTR flop
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            active_id <= '0;
            intr_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            active_id <= active_id_nxt;
            intr_q    <= intr_nxt;
        end
    end

    // Next-state logic; the timer counts down and the phase ends as it reaches zero
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        active_id_nxt = active_id;
        case (state)
            ST_IDLE: begin
                if (|elig) begin
                    active_id_nxt = win_id;
                    cnt_nxt       = CNT_W'(INTR_CYCLES);
                    state_nxt     = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (claim_match) begin
                    cnt_nxt   = CNT_W'(GAP_CYCLES);
                    state_nxt = ST_GAP;
                end else if (cnt <= CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_ACK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (claim_match) begin
                    cnt_nxt   = CNT_W'(GAP_CYCLES);
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: INTR is registered from the next state; CLAIM is visible while an ID is held
    always_comb begin
        intr_nxt  = (state_nxt == ST_ASSERT);
        claim_vis = (state == ST_ASSERT) || (state == ST_WAIT_ACK);
    end

    // Combinational read mux, zero when the address misses all three registers
    always_comb begin
        RD_DATA = '0;
        if (hit_pend) begin
            RD_DATA = 32'(pend);
        end else if (hit_mask) begin
            RD_DATA = 32'(mask);
        end else if (hit_claim && claim_vis) begin
            RD_DATA = {1'b1, 27'b0, active_id};
        end
    end

    assign RD_HIT = hit_pend | hit_mask | hit_claim;
    assign INTR   = intr_q;

endmodule
